// File: rtl/merge3to1_rr.sv
// Three-channel round-robin byte merger with a registered, tagged valid/ready output stage.
// Latency 1 cycle; Ready is only offered when the output register is empty or draining. Optional counters: MERGE3TO1_COUNT_EN.
module merge3to1_rr #(
   parameter int         WIDTH = 8,
   parameter logic [2:0] TAG_A = 3'b001,
   parameter logic [2:0] TAG_B = 3'b010,
   parameter logic [2:0] TAG_C = 3'b011
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] InA,
   input  logic             ValidA,
   output logic             ReadyA,
   input  logic [WIDTH-1:0] InB,
   input  logic             ValidB,
   output logic             ReadyB,
   input  logic [WIDTH-1:0] InC,
   input  logic             ValidC,
   output logic             ReadyC,
`ifdef MERGE3TO1_COUNT_EN
   output logic [7:0]       CountA,
   output logic [7:0]       CountB,
   output logic [7:0]       CountC,
`endif
   output logic [WIDTH-1:0] Out,
   output logic [2:0]       Sel,
   output logic             OutValid,
   input  logic             OutReady
);

   typedef enum logic {EMPTY, FULL} state_e;
   typedef enum logic [1:0] {CH_A, CH_B, CH_C} ch_e;

   state_e           state_q, state_d;
   ch_e              last_q, last_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [2:0]       sel_q, sel_d;
   logic             load;
   logic [2:0]       gnt;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= EMPTY;
         last_q  <= CH_C;
         out_q   <= '0;
         sel_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         out_q   <= out_d;
         sel_q   <= sel_d;
      end
   end

   assign load = (state_q == EMPTY) || OutReady;

   // Scan starts at the channel after the last winner: A->B->C->A.
   always_comb begin
      gnt = 3'b000;
      if (load) begin
         case (last_q)
            CH_A: begin
               if (ValidB)      gnt = 3'b010;
               else if (ValidC) gnt = 3'b100;
               else if (ValidA) gnt = 3'b001;
            end
            CH_B: begin
               if (ValidC)      gnt = 3'b100;
               else if (ValidA) gnt = 3'b001;
               else if (ValidB) gnt = 3'b010;
            end
            default: begin
               if (ValidA)      gnt = 3'b001;
               else if (ValidB) gnt = 3'b010;
               else if (ValidC) gnt = 3'b100;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      out_d   = out_q;
      sel_d   = sel_q;
      if (gnt[0]) begin
         out_d = InA; sel_d = TAG_A; last_d = CH_A; state_d = FULL;
      end else if (gnt[1]) begin
         out_d = InB; sel_d = TAG_B; last_d = CH_B; state_d = FULL;
      end else if (gnt[2]) begin
         out_d = InC; sel_d = TAG_C; last_d = CH_C; state_d = FULL;
      end else if (state_q == FULL && OutReady) begin
         // Drained with nothing to refill: data and tag keep their last values.
         state_d = EMPTY;
      end
   end

   // Ready is masked during reset without feeding Reset back into the flops.
   assign ReadyA   = gnt[0] & ~Reset;
   assign ReadyB   = gnt[1] & ~Reset;
   assign ReadyC   = gnt[2] & ~Reset;
   assign Out      = out_q;
   assign Sel      = sel_q;
   assign OutValid = (state_q == FULL);

`ifdef MERGE3TO1_COUNT_EN
   logic [7:0] cnt_a_q, cnt_b_q, cnt_c_q;

   // Saturating per-channel transfer counts.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt_a_q <= 8'd0;
         cnt_b_q <= 8'd0;
         cnt_c_q <= 8'd0;
      end else begin
         if (gnt[0] && cnt_a_q != 8'hFF) cnt_a_q <= cnt_a_q + 8'd1;
         if (gnt[1] && cnt_b_q != 8'hFF) cnt_b_q <= cnt_b_q + 8'd1;
         if (gnt[2] && cnt_c_q != 8'hFF) cnt_c_q <= cnt_c_q + 8'd1;
      end
   end

   assign CountA = cnt_a_q;
   assign CountB = cnt_b_q;
   assign CountC = cnt_c_q;
`endif

endmodule

// File: doc/merge3to1_rr.md
Name: merge3to1_rr

Overview:
- Three-input, 8-bit round-robin merger: the transmit-side counterpart of the 1-to-3 channel demultiplexer.
- Collects bytes from channels A, B and C and forwards one byte per transfer on a single output.
- Each output byte carries a 3-bit Sel tag in the demux select encoding, so the downstream demux routes it back to the matching channel.
- The output stage is registered and uses a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of every channel and of Out.
- TAG_A, 3'b001, Sel tag emitted for channel A.
- TAG_B, 3'b010, Sel tag emitted for channel B.
- TAG_C, 3'b011, Sel tag emitted for channel C.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- InA  input  WIDTH  channel A data
- ValidA  input  1  channel A byte offered
- ReadyA  output  1  channel A byte accepted this cycle
- InB  input  WIDTH  channel B data
- ValidB  input  1  channel B byte offered
- ReadyB  output  1  channel B byte accepted this cycle
- InC  input  WIDTH  channel C data
- ValidC  input  1  channel C byte offered
- ReadyC  output  1  channel C byte accepted this cycle
- Out  output  WIDTH  merged data, registered
- Sel  output  3  tag of the channel that sourced Out, registered
- OutValid  output  1  Out/Sel hold a byte
- OutReady  input  1  downstream accepts Out this cycle

Behaviour:
- One clock domain (Clock). Reset is asynchronous, active-high.
- Reset values:
  - Out = 0, Sel = 3'b000, OutValid = 0.
  - Last = C, so channel A has first priority after reset.
  - ReadyA/B/C = 0 while Reset is high.
- Output register states:
  - EMPTY: OutValid = 0.
  - FULL: OutValid = 1.
- Load condition: Load = (state == EMPTY) or (OutReady == 1).
- Arbitration (combinational, only when Load = 1):
  - Scan channels starting at the one after Last, in the order A→B→C→A.
  - Grant the first channel whose Valid = 1.
  - Assert Ready only for the granted channel.
  - At most one Ready is high in any cycle.
- Transfer on channel X happens when ValidX and ReadyX are both high. At the next rising edge:
  - Out ← InX, Sel ← TAG_X, OutValid ← 1, Last ← X.
- Drain without refill: if OutReady = 1 and no channel is valid, then next OutValid = 0. Out and Sel hold their last values; Sel is not cleared.
- FULL and OutReady = 0: all Ready are low and Out/Sel/OutValid hold. Upstream data may change freely while Ready is low.
- Latency: accepted byte appears on Out one cycle later.
- Throughput: one byte per cycle when OutReady is held high. Drain and refill in the same cycle causes no bubble.
- Fairness: with all three channels continuously valid, the grant order is A, B, C, A, ... and no channel waits more than 2 transfers.
- OutValid never drops while OutReady = 0 (no retraction of a presented byte).
- Reset asserted mid-transfer: the byte in the output register is discarded immediately. The arbiter returns to Last = C.
- Tag width is fixed at 3. TAG_x values must be distinct and non-zero; Sel = 000 means "no byte yet since reset".

Optional Feature:
- Macro: MERGE3TO1_COUNT_EN.
- Defined:
  - Adds output ports CountA, CountB, CountC, each 8 bits.
  - Each is a per-channel count of accepted transfers.
  - Counters reset to 0 and increment on the channel's Valid&&Ready.
  - Counters saturate at 255; no wrap.
- Undefined: ports and counters are absent. Datapath and handshake timing are identical in both builds.

Test Plan:
- Reset, then ValidB = 1 with InB = 8'h5A and OutReady = 1 → ReadyB = 1 in cycle 0; cycle 1 shows Out = 8'h5A, Sel = 3'b010, OutValid = 1; cycle 2 shows OutValid = 0.
- All Valid held high (InA = 8'h11, InB = 8'h22, InC = 8'h33), OutReady = 1 for 6 cycles → Sel sequence 001, 010, 011, 001, 010, 011, one byte per cycle, exactly one Ready high each cycle.
- Output FULL with Out = 8'hA1, then OutReady = 0 for 4 cycles with ValidC = 1 → all Ready low; Out stays 8'hA1. OutReady = 1 → ReadyC = 1 the same cycle; the next cycle shows Sel = 3'b011.
- Reset pulsed while OutValid = 1 and Out = 8'hFF → OutValid = 0, Out = 0, Sel = 0 immediately. After release, with ValidA and ValidC both high, A is granted first.
- Only ValidA high for 3 transfers, then ValidB and ValidA both high → B is granted next (round-robin after A).
- With MERGE3TO1_COUNT_EN defined: 300 channel A transfers → CountA = 255, CountB = 0, CountC = 0. Build without the macro and rerun the other scenarios → identical Out/Sel traces.
